// File: rtl/writeback_commit_arbiter_pkg.sv
// writeback_commit_arbiter_pkg: shared types and default sizing for the register-file writeback path
package writeback_commit_arbiter_pkg;
    localparam int NUM_WB_UNITS = 3;
    localparam int FIFO_DEPTH = 2;
    typedef logic [4:0] rs_addr_t;
    typedef struct packed {
        rs_addr_t rd;
        logic [31:0] data;
    } wb_entry_t;
    typedef logic [$clog2(NUM_WB_UNITS)-1:0] wb_unit_id_t;
endpackage

// File: rtl/writeback_commit_arbiter_fifo.sv
// wb_fifo: single-clock FIFO of writeback entries with naturally wrapping pointers
module wb_fifo
    import writeback_commit_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  wb_entry_t                  din,
    output wb_entry_t                  dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        mem_d[wptr_q] = push ? din : mem_q[wptr_q];
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
        end
    end
    assign dout = mem_q[rptr_q];
    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/writeback_commit_arbiter.sv
// writeback_commit_arbiter: round-robin serialisation of unit results onto the register-file write port
module writeback_commit_arbiter #(
    parameter int NUM_WB_UNITS = writeback_commit_arbiter_pkg::NUM_WB_UNITS,
    parameter int FIFO_DEPTH = writeback_commit_arbiter_pkg::FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WB_UNITS-1:0]      wb_valid,
    output logic [NUM_WB_UNITS-1:0]      wb_ready,
    input  logic [5*NUM_WB_UNITS-1:0]    wb_rd,
    input  logic [32*NUM_WB_UNITS-1:0]   wb_data,
    output logic [4:0]                   rd_addr,
    output logic [31:0]                  new_data,
    output logic                         commit,
    output logic                         idle
);
    import writeback_commit_arbiter_pkg::*;
    localparam int UW = $clog2(NUM_WB_UNITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    wb_entry_t heads [NUM_WB_UNITS];
    logic [CW-1:0] counts [NUM_WB_UNITS];
    logic [NUM_WB_UNITS-1:0] full, empty, pop;
    logic [UW-1:0] last_grant_q, last_grant_d, grant_id, idx;
    logic grant_valid;
    wb_entry_t head;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic [31:0] new_data_q, new_data_d;
    logic commit_q, commit_d;
    for (genvar g = 0; g < NUM_WB_UNITS; g++) begin : g_unit
        wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (wb_valid[g] & wb_ready[g]),
            .pop   (pop[g]),
            .din   ({wb_rd[5*g +: 5], wb_data[32*g +: 32]}),
            .dout  (heads[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (counts[g])
        );
        assign wb_ready[g] = rst & ~full[g];
        assign pop[g] = grant_valid && grant_id == UW'(g);
    end
    // Walk the units starting just after the last winner; first non-empty one wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id = last_grant_q;
        idx = last_grant_q;
        for (int k = 0; k < NUM_WB_UNITS; k++) begin
            idx = (idx == UW'(NUM_WB_UNITS - 1)) ? '0 : idx + 1'b1;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant_id = idx;
            end
        end
    end
    always_comb begin
        head = heads[grant_id];
        last_grant_d = grant_valid ? grant_id : last_grant_q;
        rd_addr_d = grant_valid ? head.rd : rd_addr_q;
        new_data_d = grant_valid ? head.data : new_data_q;
        commit_d = grant_valid && head.rd != '0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= UW'(NUM_WB_UNITS - 1);
            rd_addr_q <= '0;
            new_data_q <= '0;
            commit_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_addr_q <= rd_addr_d;
            new_data_q <= new_data_d;
            commit_q <= commit_d;
        end
    end
    always_comb begin
        idle = !commit_q;
        for (int k = 0; k < NUM_WB_UNITS; k++) idle = idle && counts[k] == '0;
    end
    assign rd_addr = rd_addr_q;
    assign new_data = new_data_q;
    assign commit = commit_q;
endmodule

// File: tb/tb_writeback_commit_arbiter.sv
// tb_writeback_commit_arbiter: scoreboard bench with hand-computed commit sequences
module tb_writeback_commit_arbiter;
    logic clk, rst;
    logic [2:0] wb_valid, wb_ready;
    logic [14:0] wb_rd;
    logic [95:0] wb_data;
    logic [4:0] rd_addr;
    logic [31:0] new_data;
    logic commit, idle;
    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;

    writeback_commit_arbiter #(.NUM_WB_UNITS(3), .FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rd_addr  (rd_addr),
        .new_data (new_data),
        .commit   (commit),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_commit(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Monitor: every commit pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit actual=%0h_%0h required=none", rd_addr, new_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_write", {27'd0, rd_addr, new_data}, {27'd0, mon_e});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_commit"}, 64'(commit), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_new_data"}, 64'(new_data), 64'd0);
        check({tag, "_idle"}, 64'(idle), 64'd1);
        check({tag, "_ready"}, 64'(wb_ready), 64'd0);
    endtask

    // All three units valid for n edges; unit u data = 0x(u+1)000 + edge,
    // with hold2 freezing unit 2 data at edge 2 so the stalled entry is held.
    task automatic burst(input int n, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input bit hold2);
        logic [4:0] exp_rdy2;
        exp_rdy2 = 5'b10011;
        for (int e = 0; e < n; e++) begin
            wb_valid = 3'b111;
            wb_rd = {r2, r1, r0};
            wb_data = {32'h3000 + 32'((hold2 && e > 2) ? 2 : e), 32'h2000 + 32'(e), 32'h1000 + 32'(e)};
            if (hold2) begin
                @(negedge clk);
                check("ready2_backpressure", 64'(wb_ready[2]), 64'(exp_rdy2[e]));
            end
            @(posedge clk); #1;
        end
        wb_valid = '0;
    endtask

    initial begin
        rst = 1'b0;
        wb_valid = '0;
        wb_rd = '0;
        wb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_reset", 64'(wb_ready), 64'h7);
        @(posedge clk); #1;

        // Single result from unit 0
        wb_valid = 3'b001;
        wb_rd = 15'd5;
        wb_data = {64'd0, 32'hDEADBEEF};
        expect_commit(5'd5, 32'hDEADBEEF);
        @(posedge clk); #1;
        wb_valid = '0;
        @(negedge clk);
        check("single_no_early_commit", 64'(commit), 64'd0);
        @(negedge clk);
        check("single_commit", 64'(commit), 64'd1);
        @(negedge clk);
        check("single_one_cycle", 64'(commit), 64'd0);
        check("single_idle", 64'(idle), 64'd1);
        @(posedge clk); #1;

        // Contention fairness from reset
        do_reset();
        expect_commit(5'd1, 32'h1000);
        expect_commit(5'd2, 32'h2000);
        expect_commit(5'd3, 32'h3000);
        expect_commit(5'd1, 32'h1001);
        expect_commit(5'd2, 32'h2001);
        expect_commit(5'd3, 32'h3001);
        expect_commit(5'd1, 32'h1002);
        expect_commit(5'd2, 32'h2003);
        expect_commit(5'd3, 32'h3004);
        expect_commit(5'd1, 32'h1005);
        burst(6, 5'd1, 5'd2, 5'd3, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("fair_drained_idle", 64'(idle), 64'd1);
        check("fair_all_committed", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // x0 result is consumed but not committed
        wb_valid = 3'b010;
        wb_rd = '0;
        wb_data = {32'd0, 32'h12345678, 32'd0};
        @(posedge clk); #1;
        wb_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("x0_commit", 64'(commit), 64'd0);
        check("x0_rd_addr", 64'(rd_addr), 64'd0);
        check("x0_new_data", 64'(new_data), 64'h12345678);
        @(negedge clk);
        check("x0_idle", 64'(idle), 64'd1);
        check("x0_fifo1_ready", 64'(wb_ready[1]), 64'd1);
        @(posedge clk); #1;

        // Backpressure on unit 2
        do_reset();
        expect_commit(5'd7, 32'h1000);
        expect_commit(5'd8, 32'h2000);
        expect_commit(5'd9, 32'h3000);
        expect_commit(5'd7, 32'h1001);
        expect_commit(5'd8, 32'h2001);
        expect_commit(5'd9, 32'h3001);
        expect_commit(5'd7, 32'h1002);
        expect_commit(5'd8, 32'h2003);
        expect_commit(5'd9, 32'h3002);
        burst(5, 5'd7, 5'd8, 5'd9, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_drained_idle", 64'(idle), 64'd1);
        check("bp_all_committed", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a burst
        do_reset();
        expect_commit(5'd4, 32'h1000);
        burst(2, 5'd4, 5'd5, 5'd6, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("midreset_idle_after", 64'(idle), 64'd1);
        check("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_commit_arbiter.md
# writeback_commit_arbiter

Collects completed results from multiple functional units and serialises them into the single register-file write port (`rd_addr`, `new_data`, `commit`). It is the write side of the register file: per-unit FIFOs absorb bursts, a round-robin arbiter grants one result per cycle, and a registered output stage drives the register file. Writes to x0 are consumed but never committed, so x0 always reads zero.

## Interface
- `NUM_WB_UNITS`, 3: number of functional-unit writeback sources; range 2..8.
- `FIFO_DEPTH`, 2: entries per unit FIFO; power of two, 2..8.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `wb_valid`  in  NUM_WB_UNITS  unit i presents a result.
- `wb_ready`  out  NUM_WB_UNITS  unit i FIFO can accept.
- `wb_rd`  in  NUM_WB_UNITS x 5  destination register per unit.
- `wb_data`  in  NUM_WB_UNITS x 32  result value per unit.
- `rd_addr`  out  5  register-file write address.
- `new_data`  out  32  register-file write data.
- `commit`  out  1  register-file write enable.
- `idle`  out  1  all FIFOs empty and the output stage holds no valid write.

## Operation
- Accept: unit i transfers on the edge where `wb_valid[i] & wb_ready[i]`; `{wb_rd[i], wb_data[i]}` is pushed into FIFO i.
- `wb_ready[i]` = FIFO i not full. It is computed from the registered count only and does not rise combinationally on a same-cycle pop. While `rst` is low it is forced to 0.
- Arbitration: each cycle the arbiter grants one non-empty FIFO. The search starts at `(last_grant+1) mod NUM_WB_UNITS`. `last_grant` updates only on a grant.
- The granted FIFO head is popped. On the next edge the output registers load `rd_addr`/`new_data`, and `commit` is set to 1 if rd≠0, else 0.
- x0 result: the entry is popped and uses the grant slot. `commit` is 0 for that slot. `rd_addr`/`new_data` still load the entry values.
- No grant: `commit`=0 on the next edge. `rd_addr`/`new_data` hold their previous values.
- Simultaneous push and pop on the same FIFO: count is unchanged, and an entry is never lost or duplicated. A push into a FIFO with a count of FIFO_DEPTH-1 while that FIFO is also popped is legal because ready was high.
- Pointer wrap-around: FIFO read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Order: entries from one unit commit in acceptance order. No ordering is defined between units.
- Reset (`rst`=0 at an edge, including mid-operation):
  - all FIFOs empty, buffered entries discarded;
  - `last_grant` = NUM_WB_UNITS-1, so unit 0 has first priority;
  - `commit`=0, `rd_addr`=0, `new_data`=0, `idle`=1.

## Timing
- Accept at edge E. The arbiter can grant in the cycle after E, so `commit` is asserted at the earliest after edge E+1, and the register file writes at edge E+2.
- Throughput is one commit per cycle summed over all units. A single unit alone sustains one result per cycle when FIFO_DEPTH ≥ 2.
- Under full contention, each unit is granted at least once every NUM_WB_UNITS cycles.
- `idle` is combinational from the FIFO counts and the output-valid flag. It is high in the cycle after the last commit pulse.

## Structure
- Add to `taiga_types`:
  - `wb_entry_t` (packed: `rs_addr_t rd`, `logic [31:0] data`);
  - `wb_unit_id_t` (`logic [$clog2(NUM_WB_UNITS)-1:0]`).
- Add to `taiga_config`: `NUM_WB_UNITS`.
- Sub-module `wb_fifo`: a single-clock FIFO of `wb_entry_t`, depth FIFO_DEPTH, with push/pop/full/empty/count. Instantiate it NUM_WB_UNITS times.
- The arbiter and output register stay in the top module.

## Test plan
- Single result: unit 0 pushes rd=5, data=0xDEADBEEF at edge E → `commit`=1, `rd_addr`=5, `new_data`=0xDEADBEEF after edge E+1 for exactly one cycle, then `idle`=1.
- Contention fairness: all 3 units hold valid continuously with rd=1/2/3 → commits cycle 1,2,3,1,2,3… starting with unit 0 after reset.
- x0 suppression: unit 1 pushes rd=0, data=0x12345678 → entry consumed, `commit` stays 0, FIFO 1 empty afterward, `idle`=1.
- Backpressure: block grants to unit 2 by keeping units 0/1 busy, then push 2 entries into unit 2 → `wb_ready[2]`=0. The third valid is held and accepted only after a pop, and all three commit in order.
- Reset mid-operation: fill every FIFO, drive `rst`=0 for one edge → next cycle `commit`=0, `rd_addr`=0, `new_data`=0, `idle`=1, and no stale entry commits afterward.
